serdes_phase_ctrl: RTL and testbench
====================================

Name: serdes_phase_ctrl

Overview:
- Sampling-phase controller for the pin_capt oversampling front end, running in the clk300 domain.
- Consumes the capture block's edge strobe (str) and edge position (ptime, 8 sub-phases per clk300 cycle).
- Acquires the dominant edge phase by histogram, then selects the sampling phase half a cycle away and tracks drift with a windowed phase-error accumulator.
- Reports lock and loss-of-lock to the link layer.

Parameters:
- SEARCH_EDGES, 16, edges histogrammed before a phase decision.
- DRIFT_WIN, 8, edges per tracking window.
- STEP_THR, 4, accumulated signed error magnitude that triggers a one-phase step.
- LOCK_WINDOWS, 4, consecutive non-stepping windows required for lock.
- LOSS_TIMEOUT, 64, clk300 cycles without str before lock is declared lost.

Ports:
- clk300  in  1  controller clock (300 MHz domain of pin_capt).
- rst  in  1  asynchronous, active-high reset.
- en  in  1  controller enable; low forces IDLE.
- str  in  1  edge strobe from capture, one cycle per detected edge.
- ptime  in  3  edge sub-phase 0..7, valid when str=1.
- sel_phase  out  3  selected sampling phase.
- sel_valid  out  1  sel_phase meaningful (TRACK or LOCKED).
- lock  out  1  high in LOCKED only.
- phase_step  out  1  one-cycle pulse, cycle after sel_phase changes in TRACK/LOCKED.
- state  out  3  IDLE=0, SEARCH=1, DECIDE=2, TRACK=3, LOCKED=4.
- err_cnt  out  8  saturating loss-of-lock count.

Behaviour:
- Clock and reset: one clock, clk300. Reset rst is asynchronous, active-high.
- Reset values: all outputs 0, state IDLE; clears histogram, accumulator, counters and err_cnt.
- err_cnt is cleared only by rst. It saturates at 255.
- en=0 in any state: next edge goes to IDLE. This clears histogram, accumulator and counters, and drives sel_valid=0 and lock=0. sel_phase and err_cnt hold.
- IDLE -> SEARCH on the first edge with en=1.
- SEARCH:
  - Each str increments bin[ptime]. Bin width is clog2(SEARCH_EDGES+1).
  - When the SEARCH_EDGES-th edge is counted, go to DECIDE.
- DECIDE (exactly one cycle):
  - str is ignored.
  - Winning bin = max count; on a tie, lowest index wins.
  - sel_phase <= (bin+4) mod 8; sel_valid <= 1; go to TRACK.
  - Histogram cleared.
- Phase error: expected edge exp = (sel_phase+4) mod 8. On str, e = (ptime-exp) mod 8, read as signed 3-bit (-4..+3).
- Accumulation: acc is signed, width clog2(DRIFT_WIN)+4, and sums e over the window.
- Window close happens on the edge accepting the DRIFT_WIN-th str. The evaluated value is A = acc + e, including the current edge.
  - |A| >= 3*DRIFT_WIN: loss. Go to SEARCH, sel_valid=0, lock=0, err_cnt+1.
  - A >= STEP_THR: sel_phase+1 mod 8 (7 wraps to 0). phase_step high the next cycle.
  - A <= -STEP_THR: sel_phase-1 mod 8 (0 wraps to 7). phase_step high the next cycle.
  - Otherwise: hold, and the quiet-window count increments.
  - acc and the edge count are cleared at every close.
- TRACK:
  - A step resets the quiet-window count.
  - When the quiet-window count reaches LOCK_WINDOWS, go to LOCKED and assert lock the same edge.
- LOCKED:
  - Steps are permitted and lock stays high.
  - Loss rules are the same as TRACK.
- Timeout: in TRACK/LOCKED, a cycle counter resets on every str. At LOSS_TIMEOUT cycles without str: go to SEARCH, lock=0, sel_valid=0, err_cnt+1.
- Simultaneous events: str in the cycle the timeout would expire wins, so no timeout fires. A loss and an en=0 in the same cycle go to IDLE, and err_cnt still increments.
- Latency: sel_phase updates on the clock edge of the closing str. phase_step and any new lock are visible one cycle after that str.

Test Plan:
- en=1, 16 str with ptime=2 -> SEARCH, then DECIDE one cycle, then TRACK; sel_phase=6, sel_valid=1, lock=0.
- From the previous state, 32 str with ptime=2 -> 4 quiet windows; state=4, lock=1 after the 32nd str; phase_step never pulses.
- LOCKED at sel_phase=7, 8 str with ptime=4 (e=+1, A=8) -> sel_phase=0 (wrap), phase_step one-cycle pulse, lock stays 1.
- Tie: 8 str with ptime=1 and 8 with ptime=5 in SEARCH -> sel_phase=5 (bin 1 wins).
- LOCKED, then no str for 64 cycles -> state=1, lock=0, sel_valid=0, err_cnt=1. A str on cycle 64 instead -> no timeout.
- rst asserted mid-TRACK, between clock edges -> all outputs 0 immediately, err_cnt=0. Separately, en=0 in LOCKED -> IDLE next edge, lock=0, err_cnt held.

Source files
------------

// File: rtl/serdes_phase_ctrl.sv
// serdes_phase_ctrl: histogram phase acquisition and windowed drift tracking
// for the pin_capt oversampling front end (clk300 domain).
module serdes_phase_ctrl #(
    parameter int SEARCH_EDGES = 16,
    parameter int DRIFT_WIN    = 8,
    parameter int STEP_THR     = 4,
    parameter int LOCK_WINDOWS = 4,
    parameter int LOSS_TIMEOUT = 64
) (
    input  logic       clk300,
    input  logic       rst,
    input  logic       en,
    input  logic       str,
    input  logic [2:0] ptime,
    output logic [2:0] sel_phase,
    output logic       sel_valid,
    output logic       lock,
    output logic       phase_step,
    output logic [2:0] state,
    output logic [7:0] err_cnt
);
    typedef enum logic [2:0] {IDLE = 3'd0, SEARCH = 3'd1, DECIDE = 3'd2, TRACK = 3'd3, LOCKED = 3'd4} st_t;
    localparam int BW = $clog2(SEARCH_EDGES + 1);
    localparam int AW = $clog2(DRIFT_WIN) + 4;
    localparam int WW = $clog2(DRIFT_WIN);
    localparam int QW = $clog2(LOCK_WINDOWS + 1);
    localparam int TW = $clog2(LOSS_TIMEOUT);
    localparam logic signed [AW-1:0] STEP_P = AW'(STEP_THR);
    localparam logic signed [AW-1:0] STEP_N = AW'(-STEP_THR);
    localparam logic signed [AW-1:0] LOSS_P = AW'(3 * DRIFT_WIN);
    localparam logic signed [AW-1:0] LOSS_N = AW'(-3 * DRIFT_WIN);
    st_t cur, nxt;
    logic [BW-1:0] bin [8];
    logic [BW-1:0] ecnt, best_c;
    logic [WW-1:0] wcnt;
    logic [QW-1:0] quiet;
    logic [TW-1:0] tcnt;
    logic signed [AW-1:0] acc, a_val;
    logic [2:0] e, best;
    logic trk, close, loss, tmo, up, dn;
    assign state     = cur;
    assign sel_valid = trk;
    assign lock      = cur == LOCKED;
    always_comb begin
        trk   = cur == TRACK || cur == LOCKED;
        e     = ptime - (sel_phase + 3'd4);
        a_val = acc + {{(AW-3){e[2]}}, e};
        close = trk && str && wcnt == WW'(DRIFT_WIN - 1);
        loss  = close && (a_val >= LOSS_P || a_val <= LOSS_N);
        up    = close && !loss && a_val >= STEP_P;
        dn    = close && !loss && a_val <= STEP_N;
        tmo   = trk && !str && tcnt == TW'(LOSS_TIMEOUT - 1);
        best   = 3'd0;
        best_c = bin[0];
        for (int i = 1; i < 8; i++)
            if (bin[i] > best_c) begin
                best_c = bin[i];
                best   = 3'(i);
            end
        nxt = cur;
        if (!en) nxt = IDLE;
        else if (cur == IDLE) nxt = SEARCH;
        else if (cur == SEARCH) nxt = (str && ecnt == BW'(SEARCH_EDGES - 1)) ? DECIDE : SEARCH;
        else if (cur == DECIDE) nxt = TRACK;
        else if (loss || tmo) nxt = SEARCH;
        else if (cur == TRACK && close && !up && !dn && quiet == QW'(LOCK_WINDOWS - 1)) nxt = LOCKED;
    end
    always_ff @(posedge clk300 or posedge rst) begin
        if (rst) begin
            cur        <= IDLE;
            sel_phase  <= 3'd0;
            phase_step <= 1'b0;
            err_cnt    <= 8'd0;
            ecnt       <= '0;
            wcnt       <= '0;
            quiet      <= '0;
            tcnt       <= '0;
            acc        <= '0;
            for (int i = 0; i < 8; i++) bin[i] <= '0;
        end else begin
            cur        <= nxt;
            phase_step <= en && (up || dn);
            if (loss || tmo) err_cnt <= (err_cnt == 8'hff) ? err_cnt : err_cnt + 8'd1;
            if (en && cur == DECIDE) sel_phase <= best + 3'd4;
            else if (en && up) sel_phase <= sel_phase + 3'd1;
            else if (en && dn) sel_phase <= sel_phase - 3'd1;
            if (!en || cur == DECIDE)
                for (int i = 0; i < 8; i++) bin[i] <= '0;
            else if (cur == SEARCH && str)
                bin[ptime] <= bin[ptime] + BW'(1);
            ecnt <= (en && cur == SEARCH) ? (str ? ecnt + BW'(1) : ecnt) : '0;
            // Tracking state restarts whenever we are not tracking or just lost the link
            if (!en || !trk || loss || tmo) begin
                acc   <= '0;
                wcnt  <= '0;
                quiet <= '0;
                tcnt  <= '0;
            end else begin
                tcnt <= str ? '0 : tcnt + TW'(1);
                if (close) begin
                    acc   <= '0;
                    wcnt  <= '0;
                    quiet <= (up || dn) ? '0 : (quiet == QW'(LOCK_WINDOWS)) ? quiet : quiet + QW'(1);
                end else if (str) begin
                    acc  <= a_val;
                    wcnt <= wcnt + WW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_serdes_phase_ctrl.sv
// tb_serdes_phase_ctrl: directed and randomized checks of serdes_phase_ctrl
// against an integer-arithmetic reference model of the phase controller.
module tb_serdes_phase_ctrl;
    localparam int SE = 16, DW = 8, ST = 4, LW = 4, LT = 64;
    logic clk300 = 1'b0, rst = 1'b1, en = 1'b0, str = 1'b0;
    logic [2:0] ptime = 3'd0;
    logic [2:0] sel_phase, state;
    logic sel_valid, lock, phase_step;
    logic [7:0] err_cnt;
    int checks = 0, errors = 0;
    int m_state, m_sel, m_step, m_err, m_ecnt, m_acc, m_wcnt, m_quiet, m_idle;
    int hist [8];

    serdes_phase_ctrl dut (
        .clk300(clk300), .rst(rst), .en(en), .str(str), .ptime(ptime),
        .sel_phase(sel_phase), .sel_valid(sel_valid), .lock(lock),
        .phase_step(phase_step), .state(state), .err_cnt(err_cnt)
    );

    always #5 clk300 = ~clk300;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_track();
        m_acc = 0; m_wcnt = 0; m_quiet = 0; m_idle = 0;
    endtask

    task automatic model_reset();
        m_state = 0; m_sel = 0; m_step = 0; m_err = 0; m_ecnt = 0;
        foreach (hist[i]) hist[i] = 0;
        clear_track();
    endtask

    task automatic model_edge(input bit e_i, input bit s_i, input int p);
        int ns, nsel, e, a, w;
        bit stp, lost;
        ns = m_state; nsel = m_sel; stp = 0; lost = 0;
        if (m_state == 3 || m_state == 4) begin
            if (s_i) begin
                m_idle = 0;
                m_wcnt++;
                e = (p - m_sel + 12) % 8;
                if (e >= 4) e -= 8;
                a = m_acc + e;
                if (m_wcnt == DW) begin
                    m_wcnt = 0; m_acc = 0;
                    if (a >= 3*DW || a <= -3*DW) lost = 1;
                    else if (a >= ST) begin nsel = (m_sel + 1) % 8; stp = 1; m_quiet = 0; end
                    else if (a <= -ST) begin nsel = (m_sel + 7) % 8; stp = 1; m_quiet = 0; end
                    else begin
                        m_quiet++;
                        if (m_state == 3 && m_quiet == LW) ns = 4;
                    end
                end else m_acc = a;
            end else begin
                m_idle++;
                if (m_idle == LT) lost = 1;
            end
            if (lost) begin
                if (m_err < 255) m_err++;
                ns = 1;
                clear_track();
            end
        end else if (m_state == 1) begin
            if (s_i) begin
                hist[p]++;
                m_ecnt++;
                if (m_ecnt == SE) ns = 2;
            end
        end else if (m_state == 2) begin
            w = 0;
            for (int i = 1; i < 8; i++) if (hist[i] > hist[w]) w = i;
            nsel = (w + 4) % 8; ns = 3; m_ecnt = 0;
            foreach (hist[i]) hist[i] = 0;
            clear_track();
        end else ns = 1;
        if (!e_i) begin
            ns = 0; nsel = m_sel; stp = 0; m_ecnt = 0;
            foreach (hist[i]) hist[i] = 0;
            clear_track();
        end
        m_state = ns; m_sel = nsel; m_step = stp;
    endtask

    task automatic compare();
        chk("state", state, m_state);
        chk("sel_phase", sel_phase, m_sel);
        chk("sel_valid", sel_valid, (m_state == 3 || m_state == 4) ? 1 : 0);
        chk("lock", lock, (m_state == 4) ? 1 : 0);
        chk("phase_step", phase_step, m_step);
        chk("err_cnt", err_cnt, m_err);
    endtask

    task automatic cycle(input bit e_i, input bit s_i, input int p);
        en = e_i; str = s_i; ptime = 3'(p);
        @(posedge clk300);
        model_edge(e_i, s_i, p);
        #1 compare();
    endtask

    initial begin
        int mode, center, p;
        model_reset();
        #12;
        chk("rst_state", state, 0);
        chk("rst_outs", {sel_phase, sel_valid, lock, phase_step, err_cnt}, 0);
        rst = 1'b0;
        cycle(1, 0, 0); cycle(1, 0, 0);
        for (int i = 0; i < 16; i++) cycle(1, 1, 2);
        chk("decide_state", state, 2);
        cycle(1, 0, 0);
        chk("track_state", state, 3);
        chk("acq_sel", sel_phase, 6);
        chk("acq_valid", sel_valid, 1);
        for (int i = 0; i < 32; i++) cycle(1, 1, 2);
        chk("lock32", lock, 1);
        for (int i = 0; i < 8; i++) cycle(1, 1, 3);
        chk("step_to7", sel_phase, 7);
        for (int i = 0; i < 8; i++) cycle(1, 1, 4);
        chk("wrap_sel", sel_phase, 0);
        chk("wrap_step", phase_step, 1);
        chk("wrap_lock", lock, 1);
        cycle(1, 0, 0);
        chk("step_pulse_end", phase_step, 0);
        for (int i = 0; i < 63; i++) cycle(1, 0, 0);
        chk("timeout_state", state, 1);
        chk("timeout_err", err_cnt, 1);
        chk("timeout_lock", lock, 0);
        for (int i = 0; i < 8; i++) begin cycle(1, 1, 1); cycle(1, 1, 5); end
        cycle(1, 0, 0);
        chk("tie_sel", sel_phase, 5);
        for (int i = 0; i < 32; i++) cycle(1, 1, 1);
        for (int i = 0; i < 63; i++) cycle(1, 0, 0);
        cycle(1, 1, 1);
        chk("str_at_64", state, 4);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0);
        cycle(0, 0, 0);
        chk("en0_state", state, 0);
        chk("en0_err", err_cnt, 1);
        chk("en0_sel", sel_phase, 5);
        cycle(1, 0, 0);
        for (int i = 0; i < 16; i++) cycle(1, 1, 0);
        for (int i = 0; i < 6; i++) cycle(1, 1, 0);
        #2 rst = 1'b1;
        #1 model_reset();
        chk("arst_state", state, 0);
        chk("arst_outs", {sel_phase, sel_valid, lock, phase_step, err_cnt}, 0);
        @(posedge clk300);
        #1 rst = 1'b0;
        mode = 0; center = 0;
        for (int n = 0; n < 5000; n++) begin
            if (n % 150 == 0) begin
                mode = $urandom_range(0, 3);
                center = $urandom_range(0, 7);
            end
            if ($urandom_range(0, 299) == 0)
                for (int k = 0; k < 70; k++) cycle(1, 0, 0);
            case (mode)
                0: p = center + 7 + $urandom_range(0, 2);
                1: p = $urandom_range(0, 7);
                2: p = m_sel;
                default: p = m_sel + 5 + $urandom_range(0, 2);
            endcase
            cycle($urandom_range(0, 499) != 0, $urandom_range(0, 1) == 1, p % 8);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
